// File: rtl/stream_pkt_gen.sv
// stream_pkt_gen: descriptor-driven packet transmitter for one crossbar input.
// A descriptor (dest, len, seed, step) becomes len+1 beats of an arithmetic
// data sequence on a valid/ready stream. The generator honours backpressure and
// counts completed packets.
module stream_pkt_gen #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DEST_WIDTH = 2,
  parameter int LEN_WIDTH    = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,        // synchronous, active-high
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [T_DEST_WIDTH-1:0] cmd_dest_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic [T_DATA_WIDTH-1:0] cmd_seed_i,
  input  logic [T_DATA_WIDTH-1:0] cmd_step_i,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_DEST_WIDTH-1:0] m_dest_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    busy_o,
  output logic [CNT_WIDTH-1:0]    pkt_cnt_o
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_q, state_d;
  logic [T_DEST_WIDTH-1:0] dest_q,  dest_d;
  logic [LEN_WIDTH-1:0]    len_q,   len_d;
  logic [T_DATA_WIDTH-1:0] step_q,  step_d;
  logic [T_DATA_WIDTH-1:0] data_q,  data_d;
  logic [LEN_WIDTH-1:0]    beat_q,  beat_d;
  logic                    last_q,  last_d;
  logic [CNT_WIDTH-1:0]    cnt_q,   cnt_d;
  logic [LEN_WIDTH-1:0]    beat_inc;

  // The beat counter is exactly LEN_WIDTH wide. The last flag stops the
  // packet at beat == len, so the increment never wraps inside a packet.
  assign beat_inc = beat_q + 1'b1;

  // Next-state logic: accept a descriptor in IDLE, advance beats on a transfer.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    dest_d  = dest_q;
    len_d   = len_q;
    step_d  = step_q;
    data_d  = data_q;
    beat_d  = beat_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = SEND;
          dest_d  = cmd_dest_i;
          len_d   = cmd_len_i;
          step_d  = cmd_step_i;
          data_d  = cmd_seed_i;
          beat_d  = '0;
          last_d  = (cmd_len_i == '0);
        end
      end
      SEND: begin
        if (m_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            data_d  = data_q + step_q;
            beat_d  = beat_inc;
            last_d  = (beat_inc == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset wins over a coincident transfer and drops the packet.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: use non-blocking assignments for all flops, so every register samples values from before the edge.
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      step_q  <= step_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs come straight from flops. cmd_ready_o also looks at reset so that
  // no descriptor appears accepted during a reset cycle.
  assign cmd_ready_o = (state_q == IDLE) & ~rst_n;
  assign m_valid_o   = (state_q == SEND);
  assign busy_o      = (state_q == SEND);
  assign m_data_o    = data_q;
  assign m_dest_o    = dest_q;
  assign m_last_o    = last_q;
  assign pkt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_stream_pkt_gen.sv
// Bench for stream_pkt_gen. Vectors from a table check single-beat, multi-beat,
// backpressure and descriptor-during-send behaviour. Hand-written sequences
// cover reset in the middle of a packet and counter wrap, using a second
// instance built with CNT_WIDTH = 2.
module tb_stream_pkt_gen;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_dest_i;
  logic [7:0] cmd_len_i;
  logic [7:0] cmd_seed_i;
  logic [7:0] cmd_step_i;
  logic [7:0] m_data_o;
  logic [1:0] m_dest_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic       busy_o;
  logic [15:0] pkt_cnt_o;

  logic       w_cmd_ready;
  logic [7:0] w_data;
  logic [1:0] w_dest;
  logic       w_last;
  logic       w_valid;
  logic       w_busy;
  logic [1:0] w_cnt;

  int checks   = 0;
  int failures = 0;

  stream_pkt_gen dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_dest_i(cmd_dest_i), .cmd_len_i(cmd_len_i),
    .cmd_seed_i(cmd_seed_i), .cmd_step_i(cmd_step_i),
    .m_data_o(m_data_o), .m_dest_o(m_dest_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .pkt_cnt_o(pkt_cnt_o)
  );

  stream_pkt_gen #(.CNT_WIDTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(w_cmd_ready),
    .cmd_dest_i(cmd_dest_i), .cmd_len_i(cmd_len_i),
    .cmd_seed_i(cmd_seed_i), .cmd_step_i(cmd_step_i),
    .m_data_o(w_data), .m_dest_o(w_dest), .m_last_o(w_last),
    .m_valid_o(w_valid), .m_ready_i(m_ready_i),
    .busy_o(w_busy), .pkt_cnt_o(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] dest;
    logic [7:0] len;
    logic [7:0] seed;
    logic [7:0] step;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [1:0] e_dest;
    logic       e_last;
    logic       e_cready;
    logic       e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic cv, logic [1:0] dest, logic [7:0] len,
                              logic [7:0] seed, logic [7:0] step, logic rdy,
                              logic e_valid, logic [7:0] e_data, logic [1:0] e_dest,
                              logic e_last, logic e_cready, logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.cv = cv; v.dest = dest; v.len = len; v.seed = seed; v.step = step;
    v.rdy = rdy; v.e_valid = e_valid; v.e_data = e_data; v.e_dest = e_dest;
    v.e_last = e_last; v.e_cready = e_cready; v.e_busy = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic cv, input logic [1:0] dest,
                       input logic [7:0] len, input logic [7:0] seed,
                       input logic [7:0] step, input logic rdy);
    rst_n = rst; cmd_valid_i = cv; cmd_dest_i = dest; cmd_len_i = len;
    cmd_seed_i = seed; cmd_step_i = step; m_ready_i = rdy;
  endtask

  logic [1:0] exp_w [5];

  initial begin
    //                rst cv  dest len    seed   step   rdy  val data   dest last crdy cnt
    vecs[0]  = mk(1'b1, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0);
    // single beat: seed A5, len 0, dest 2
    vecs[1]  = mk(1'b0, 1'b1, 2'd2, 8'd0, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd0);
    vecs[2]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA5, 2'd2, 1'b1, 1'b0, 16'd0);
    // idle after the beat; accept multi-beat F0 +8, len 3, dest 1
    vecs[3]  = mk(1'b0, 1'b1, 2'd1, 8'd3, 8'hF0, 8'h08, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd1);
    vecs[4]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hF0, 2'd1, 1'b0, 1'b0, 16'd1);
    vecs[5]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hF8, 2'd1, 1'b0, 1'b0, 16'd1);
    vecs[6]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 2'd1, 1'b0, 1'b0, 16'd1);
    vecs[7]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h08, 2'd1, 1'b1, 1'b0, 16'd1);
    // bubble, accept backpressure packet seed 10 +1, len 2, dest 3
    vecs[8]  = mk(1'b0, 1'b1, 2'd3, 8'd2, 8'h10, 8'h01, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd2);
    // ready pattern 1,0,0,1,0,1 with a competing descriptor held mid-packet
    vecs[9]  = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 2'd3, 1'b0, 1'b0, 16'd2);
    vecs[10] = mk(1'b0, 1'b1, 2'd0, 8'd0, 8'h55, 8'h00, 1'b0, 1'b1, 8'h11, 2'd3, 1'b0, 1'b0, 16'd2);
    vecs[11] = mk(1'b0, 1'b1, 2'd0, 8'd0, 8'h55, 8'h00, 1'b0, 1'b1, 8'h11, 2'd3, 1'b0, 1'b0, 16'd2);
    vecs[12] = mk(1'b0, 1'b1, 2'd0, 8'd0, 8'h55, 8'h00, 1'b1, 1'b1, 8'h11, 2'd3, 1'b0, 1'b0, 16'd2);
    vecs[13] = mk(1'b0, 1'b1, 2'd0, 8'd0, 8'h55, 8'h00, 1'b0, 1'b1, 8'h12, 2'd3, 1'b1, 1'b0, 16'd2);
    vecs[14] = mk(1'b0, 1'b1, 2'd0, 8'd0, 8'h55, 8'h00, 1'b1, 1'b1, 8'h12, 2'd3, 1'b1, 1'b0, 16'd2);
    // bubble: the pending descriptor is taken only now
    vecs[15] = mk(1'b0, 1'b1, 2'd0, 8'd0, 8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd3);
    vecs[16] = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0, 16'd3);
    vecs[17] = mk(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd4);

    exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0; exp_w[4] = 2'd1;

    drive(1'b1, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].cv, vecs[i].dest, vecs[i].len, vecs[i].seed,
            vecs[i].step, vecs[i].rdy);
      #1;
      check($sformatf("row%0d_valid", i), m_valid_o, vecs[i].e_valid);
      check($sformatf("row%0d_cready", i), cmd_ready_o, vecs[i].e_cready);
      check($sformatf("row%0d_busy", i), busy_o, vecs[i].e_busy);
      check($sformatf("row%0d_cnt", i), pkt_cnt_o, vecs[i].e_cnt);
      if (vecs[i].e_valid || vecs[i].rst) begin
        check($sformatf("row%0d_data", i), m_data_o, vecs[i].e_data);
        check($sformatf("row%0d_dest", i), m_dest_o, vecs[i].e_dest);
        check($sformatf("row%0d_last", i), m_last_o, vecs[i].e_last);
      end
    end

    // Reset mid-packet: len 5, seed 20, step 2; reset lands with ready high on beat 3.
    @(negedge clk); drive(1'b0, 1'b1, 2'd1, 8'd5, 8'h20, 8'h02, 1'b1); #1;
    check("rstmid_accept_cready", cmd_ready_o, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1); #1;
    check("rstmid_beat0", m_data_o, 8'h20);
    @(negedge clk); #1;
    check("rstmid_beat1", m_data_o, 8'h22);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rstmid_beat2", m_data_o, 8'h24);
    check("rstmid_cready_in_rst", cmd_ready_o, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 2'd2, 8'd0, 8'h77, 8'h00, 1'b0); #1;
    check("rstmid_valid_dropped", m_valid_o, 1'b0);
    check("rstmid_busy", busy_o, 1'b0);
    check("rstmid_cnt", pkt_cnt_o, 16'd0);
    check("rstmid_cready_after", cmd_ready_o, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 2'd0, 8'd0, 8'h00, 8'h00, 1'b1); #1;
    check("rstmid_new_valid", m_valid_o, 1'b1);
    check("rstmid_new_data", m_data_o, 8'h77);
    check("rstmid_new_dest", m_dest_o, 2'd2);
    check("rstmid_new_last", m_last_o, 1'b1);
    @(negedge clk); #1;
    check("rstmid_new_cnt", pkt_cnt_o, 16'd1);

    // Counter wrap on the CNT_WIDTH = 2 instance: 5 single-beat packets.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0; #1;
    check("wrap_cnt_reset", w_cnt, 2'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive(1'b0, 1'b1, 2'd0, 8'd0, 8'(k), 8'h00, 1'b1); #1;
      check($sformatf("wrap%0d_cready", k), w_cmd_ready, 1'b1);
      @(negedge clk); cmd_valid_i = 1'b0; #1;
      check($sformatf("wrap%0d_last", k), w_last, 1'b1);
      check($sformatf("wrap%0d_data", k), w_data, 8'(k));
      @(negedge clk); #1;
      check($sformatf("wrap%0d_wcnt", k), w_cnt, exp_w[k]);
      check($sformatf("wrap%0d_cnt", k), pkt_cnt_o, 16'(k + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
